// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake state and the data word.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // RAM handshake reported back to the memory controller.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/diaosi_types_pkg.sv
// Arbiter-local types: grant FSM states and client identifiers.
package diaosi_types_pkg;

  // The state register is the only record of which client owns the RAM.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2
  } arb_state_t;

  // Identifies the last client served (round-robin build only).
  typedef enum logic {
    CL_I = 1'b0,
    CL_D = 1'b1
  } client_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: icache/dcache -> single RAM port arbiter.
// One word transaction outstanding; grant held until RAM reports ACCESS.
// Optional build macro ARB_ROUND_ROBIN_EN: round-robin on simultaneous
// requests instead of fixed dcache-first priority.
module mem_arbiter
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          nRST,
  // icache
  input  logic          iREN,
  input  logic [AW-1:0] iaddr,
  output logic          iwait,
  output logic [DW-1:0] iload,
  // dcache
  input  logic          dREN,
  input  logic          dWEN,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dstore,
  output logic          dwait,
  output logic [DW-1:0] dload,
  // RAM
  output logic          ramREN,
  output logic          ramWEN,
  output logic [AW-1:0] ramaddr,
  output logic [DW-1:0] ramstore,
  input  logic [DW-1:0] ramload,
  input  ramstate_t     ramstate
);

  arb_state_t state, next_state;

  logic d_req, i_req;
  logic ram_done;

  assign d_req    = dREN | dWEN;
  assign i_req    = iREN;
  assign ram_done = (ramstate == ACCESS);

`ifdef ARB_ROUND_ROBIN_EN
  client_t last_gnt;
  logic    d_done, i_done;

  // Completion pulses for the granted client; aborts never count.
  assign d_done = (state == GNT_D) && d_req && ram_done;
  assign i_done = (state == GNT_I) && i_req && ram_done;

  // Remember who was served last so a tie goes to the other client.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)       last_gnt <= CL_I;
    else if (d_done) last_gnt <= CL_D;
    else if (i_done) last_gnt <= CL_I;
  end
`endif

  // Grant register; async reset aborts any transaction in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and output mux on the grant; outputs default to the idle/reset view.
  always_comb begin
    next_state = state;
    iwait      = 1'b1;
    dwait      = 1'b1;
    iload      = '0;
    dload      = '0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;

    unique case (state)
      IDLE: begin
        if (d_req && i_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          next_state = (last_gnt == CL_D) ? GNT_I : GNT_D;
`else
          next_state = GNT_D;
`endif
        end else if (d_req) begin
          next_state = GNT_D;
        end else if (i_req) begin
          next_state = GNT_I;
        end
      end

      GNT_D: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;   // writeback wins if both are raised
        if (!d_req) begin
          next_state = IDLE;       // client withdrew: no completion
        end else if (ram_done) begin
          dwait      = 1'b0;
          dload      = ramload;
          next_state = IDLE;
        end
        // FREE/BUSY/ERROR: hold grant and keep driving (ERROR retries)
      end

      GNT_I: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (!i_req) begin
          next_state = IDLE;
        end else if (ram_done) begin
          iwait      = 1'b0;
          iload      = ramload;
          next_state = IDLE;
        end
      end

      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
  ramstate_t   ramstate;

  int n_chk  = 0;
  int n_fail = 0;

  mem_arbiter #(.AW(32), .DW(32)) u_dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1;
    iaddr = 32'h44; daddr = 32'h88; dstore = 32'h5555_AAAA;
    ramload = 32'hFFFF_0000; ramstate = ACCESS;
    tick(); tick();
    n_chk++; if (iwait !== 1'b1) begin n_fail++; $display("FAIL rst_iwait got %b exp 1", iwait); end
    n_chk++; if (dwait !== 1'b1) begin n_fail++; $display("FAIL rst_dwait got %b exp 1", dwait); end
    n_chk++; if ({ramREN, ramWEN} !== 2'b00) begin n_fail++; $display("FAIL rst_en got %b exp 00", {ramREN, ramWEN}); end
    n_chk++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin n_fail++; $display("FAIL rst_ram got %h/%h exp 0/0", ramaddr, ramstore); end
    n_chk++; if (iload !== 32'h0 || dload !== 32'h0) begin n_fail++; $display("FAIL rst_load got %h/%h exp 0/0", iload, dload); end
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    #1 nRST = 1'b1;
    tick();
  endtask

  // icache read, two BUSY cycles then ACCESS
  task automatic test_iread();
    iREN = 1'b1; iaddr = 32'h100; dstore = 32'hFFFF_FFFF; #1;
    n_chk++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin n_fail++; $display("FAIL rd_c0 got ren=%b iwait=%b exp 0/1", ramREN, iwait); end
    tick(); ramstate = BUSY; #1;
    n_chk++; if (ramREN !== 1'b1 || ramaddr !== 32'h100 || ramWEN !== 1'b0) begin n_fail++; $display("FAIL rd_c1 got ren=%b wen=%b addr=%h exp 1/0/100", ramREN, ramWEN, ramaddr); end
    n_chk++; if (iwait !== 1'b1 || ramstore !== 32'h0) begin n_fail++; $display("FAIL rd_c1_wait got iwait=%b store=%h exp 1/0", iwait, ramstore); end
    tick(); #1;
    n_chk++; if (ramREN !== 1'b1 || iwait !== 1'b1) begin n_fail++; $display("FAIL rd_c2 got ren=%b iwait=%b exp 1/1", ramREN, iwait); end
    tick(); ramstate = ACCESS; ramload = 32'h1234_5678; #1;
    n_chk++; if (iwait !== 1'b0 || iload !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_done got iwait=%b iload=%h exp 0/12345678", iwait, iload); end
    n_chk++; if (dwait !== 1'b1 || dload !== 32'h0) begin n_fail++; $display("FAIL rd_other got dwait=%b dload=%h exp 1/0", dwait, dload); end
    tick(); iREN = 1'b0; ramstate = FREE; #1;
    n_chk++; if (ramREN !== 1'b0 || iwait !== 1'b1 || iload !== 32'h0) begin n_fail++; $display("FAIL rd_idle got ren=%b iwait=%b iload=%h exp 0/1/0", ramREN, iwait, iload); end
  endtask

  // dcache writeback, with dREN also high to exercise write priority
  task automatic test_dwrite();
    dWEN = 1'b1; dREN = 1'b1; daddr = 32'h2008; dstore = 32'hDEAD_BEEF;
    tick(); ramstate = BUSY; #1;
    n_chk++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin n_fail++; $display("FAIL wr_en got wen=%b ren=%b exp 1/0", ramWEN, ramREN); end
    n_chk++; if (ramaddr !== 32'h2008 || ramstore !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_bus got %h/%h exp 2008/deadbeef", ramaddr, ramstore); end
    n_chk++; if (dwait !== 1'b1) begin n_fail++; $display("FAIL wr_busy got dwait=%b exp 1", dwait); end
    tick(); ramstate = ACCESS; ramload = 32'h0BAD_F00D; #1;
    n_chk++; if (dwait !== 1'b0 || iwait !== 1'b1 || iload !== 32'h0) begin n_fail++; $display("FAIL wr_done got dwait=%b iwait=%b iload=%h exp 0/1/0", dwait, iwait, iload); end
    tick(); dWEN = 1'b0; dREN = 1'b0; ramstate = FREE; #1;
    n_chk++; if (ramWEN !== 1'b0 || dwait !== 1'b1) begin n_fail++; $display("FAIL wr_idle got wen=%b dwait=%b exp 0/1", ramWEN, dwait); end
  endtask

  // Simultaneous requests; last served before this is dcache
  task automatic test_both();
    logic        first_d;
    logic [31:0] a_first, a_second;
    first_d  = !RR;
    a_first  = first_d ? 32'h80 : 32'h40;
    a_second = first_d ? 32'h40 : 32'h80;
    iREN = 1'b1; iaddr = 32'h40; dREN = 1'b1; daddr = 32'h80;
    tick(); ramstate = ACCESS; ramload = 32'hAAAA_0001; #1;
    n_chk++; if (ramaddr !== a_first) begin n_fail++; $display("FAIL both_first got %h exp %h", ramaddr, a_first); end
    n_chk++; if ((first_d ? dwait : iwait) !== 1'b0 || (first_d ? iwait : dwait) !== 1'b1) begin n_fail++; $display("FAIL both_first_wait got i=%b d=%b", iwait, dwait); end
    tick(); if (first_d) dREN = 1'b0; else iREN = 1'b0; ramstate = FREE; #1;
    n_chk++; if (ramREN !== 1'b0 || iwait !== 1'b1 || dwait !== 1'b1) begin n_fail++; $display("FAIL both_idle got ren=%b i=%b d=%b exp 0/1/1", ramREN, iwait, dwait); end
    tick(); ramstate = ACCESS; ramload = 32'hAAAA_0002; #1;
    n_chk++; if (ramaddr !== a_second) begin n_fail++; $display("FAIL both_second got %h exp %h", ramaddr, a_second); end
    n_chk++; if ((first_d ? iload : dload) !== 32'hAAAA_0002) begin n_fail++; $display("FAIL both_second_load got i=%h d=%h exp aaaa0002", iload, dload); end
    tick(); iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
    // second tie: the client served last is now a_second's owner
    iREN = 1'b1; dREN = 1'b1;
    tick(); ramstate = ACCESS; #1;
    n_chk++; if (ramaddr !== (RR ? a_first : 32'h80)) begin n_fail++; $display("FAIL both_tie2 got %h exp %h", ramaddr, RR ? a_first : 32'h80); end
    tick(); iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
    tick();
  endtask

  // ERROR cycles keep the request driven until ACCESS
  task automatic test_error();
    dREN = 1'b1; daddr = 32'h300;
    tick();
    for (int k = 0; k < 3; k++) begin
      ramstate = ERROR; #1;
      n_chk++; if (ramREN !== 1'b1 || dwait !== 1'b1 || ramaddr !== 32'h300) begin n_fail++; $display("FAIL err_hold%0d got ren=%b dwait=%b addr=%h exp 1/1/300", k, ramREN, dwait, ramaddr); end
      tick();
    end
    ramstate = ACCESS; ramload = 32'hC0DE_0004; #1;
    n_chk++; if (dwait !== 1'b0 || dload !== 32'hC0DE_0004) begin n_fail++; $display("FAIL err_done got dwait=%b dload=%h exp 0/c0de0004", dwait, dload); end
    tick(); dREN = 1'b0; ramstate = FREE;
    tick();
  endtask

  // icache withdraws mid-grant; pending dcache read follows
  task automatic test_drop();
    iREN = 1'b1; iaddr = 32'h500;
    tick(); ramstate = BUSY; #1;
    n_chk++; if (ramREN !== 1'b1 || ramaddr !== 32'h500) begin n_fail++; $display("FAIL drop_gnt got ren=%b addr=%h exp 1/500", ramREN, ramaddr); end
    tick(); iREN = 1'b0; dREN = 1'b1; daddr = 32'h600; ramstate = ACCESS; #1;
    n_chk++; if (ramREN !== 1'b0 || iwait !== 1'b1 || dwait !== 1'b1) begin n_fail++; $display("FAIL drop_cyc got ren=%b i=%b d=%b exp 0/1/1", ramREN, iwait, dwait); end
    tick(); ramstate = BUSY; #1;
    n_chk++; if (ramREN !== 1'b0 || dwait !== 1'b1) begin n_fail++; $display("FAIL drop_idle got ren=%b dwait=%b exp 0/1", ramREN, dwait); end
    tick(); #1;
    n_chk++; if (ramREN !== 1'b1 || ramaddr !== 32'h600) begin n_fail++; $display("FAIL drop_next got ren=%b addr=%h exp 1/600", ramREN, ramaddr); end
    ramstate = ACCESS; tick(); dREN = 1'b0; ramstate = FREE;
    tick();
  endtask

  // Async reset during a BUSY dcache grant
  task automatic test_reset_mid();
    dWEN = 1'b1; daddr = 32'h700; dstore = 32'h7777_7777;
    tick(); ramstate = BUSY; #1;
    n_chk++; if (ramWEN !== 1'b1) begin n_fail++; $display("FAIL rstm_pre got wen=%b exp 1", ramWEN); end
    #1 nRST = 1'b0; #1;
    n_chk++; if ({ramREN, ramWEN, dwait, iwait} !== 4'b0011) begin n_fail++; $display("FAIL rstm_out got %b exp 0011", {ramREN, ramWEN, dwait, iwait}); end
    n_chk++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin n_fail++; $display("FAIL rstm_bus got %h/%h exp 0/0", ramaddr, ramstore); end
    dWEN = 1'b0; ramstate = FREE;
    tick(); nRST = 1'b1; tick();
    n_chk++; if (u_dut.state !== IDLE || ramWEN !== 1'b0) begin n_fail++; $display("FAIL rstm_idle got state=%0d wen=%b exp IDLE/0", u_dut.state, ramWEN); end
  endtask

  initial begin
    test_reset();
    test_iread();
    test_dwrite();
    test_both();
    test_error();
    test_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
